// File: rtl/pipe_pkg.sv
// Shared pipeline definitions for the EX-stage operand-select logic.
// Holds the forward-mux encodings, the register-index width and the
// per-stage shadow record the hazard unit uses to track in-flight
// destination registers.
package pipe_pkg;

    localparam int REG_ADDR_W = 5;

    // Operand-mux select encodings driven to the EX stage
    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    // Destination-register shadow of one pipeline stage
    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] rd;
        logic                  reg_write;
        logic                  mem_read;
    } stage_t;

    // An empty stage: what a bubble or a flushed slot looks like
    function automatic stage_t bubble_stage();
        stage_t s;
        s = '0;
        return s;
    endfunction

endpackage

// File: rtl/fwd_select.sv
// Per-operand forwarding priority select (purely combinational).
// Given one source register of the instruction in ID and the shadows of
// the instructions currently in EX and MEM, decides where that operand
// must come from once the instruction reaches EX next cycle.
//
// Ports:
//   i_src       source register index read by the ID instruction
//   i_use       the ID instruction actually reads i_src
//   i_ex        shadow of the instruction now in EX
//   i_mem       shadow of the instruction now in MEM
//   o_hit_ex    the EX-stage instruction produces i_src
//   o_fwd_next  select value to be registered for the operand mux
module fwd_select
    import pipe_pkg::*;
#(
    parameter logic [REG_ADDR_W-1:0] ZERO_REG = '0
) (
    input  logic [REG_ADDR_W-1:0] i_src,
    input  logic                  i_use,
    input  stage_t                i_ex,
    input  stage_t                i_mem,
    output logic                  o_hit_ex,
    output logic [1:0]            o_fwd_next
);

    logic w_src_live;
    logic w_hit_mem;
    logic w_unused_mem_read;

    // A zero-register source never needs a forward or a stall
    assign w_src_live = i_use & (i_src != ZERO_REG);

    assign o_hit_ex  = w_src_live & i_ex.valid  & i_ex.reg_write  & (i_ex.rd  == i_src);
    assign w_hit_mem = w_src_live & i_mem.valid & i_mem.reg_write & (i_mem.rd == i_src);

    // Whether the MEM producer was a load does not matter: by the time the
    // consumer is in EX it sits in WB and its data is on Write_data.
    assign w_unused_mem_read = i_mem.mem_read;

    // The newest producer wins. A load in EX cannot be forwarded from MEM;
    // that case is a load-use stall and is cleared by the top level.
    always_comb begin
        o_fwd_next = FWD_RF;
        if (o_hit_ex && !i_ex.mem_read) begin
            o_fwd_next = FWD_MEM;
        end else if (w_hit_mem) begin
            o_fwd_next = FWD_WB;
        end
    end

endmodule

// File: rtl/forwarding_hazard_unit.sv
// Forwarding and load-use hazard unit for the 5-stage pipeline.
// Shadows rd/reg_write/mem_read for EX, MEM and WB, registers the
// ForwardA/ForwardB operand selects so they line up with the instruction
// occupying EX, and raises a one-cycle load-use stall with an ID/EX bubble.
//
// Optional build macro: HAZ_PERF_CNT_EN adds stall_cnt and fwd_cnt
// performance counters; without it those ports and counters do not exist.
//
// Ports:
//   clk, rst_n        rising-edge clock, asynchronous active-low reset
//   id_valid          ID holds a real instruction
//   id_rs1, id_rs2    source indices, with id_use_rs1/id_use_rs2 read flags
//   id_rd             destination index, id_reg_write/id_mem_read flags
//   flush             taken branch/jump in EX kills the ID instruction
//   stall             hold PC and IF/ID
//   ex_bubble         ID/EX loads a NOP on this edge
//   ForwardA/B        registered operand selects for the EX instruction
//   stall_cnt/fwd_cnt (HAZ_PERF_CNT_EN only) wrapping event counters
module forwarding_hazard_unit #(
    parameter int                                REG_ADDR_W = 5,
    parameter logic [pipe_pkg::REG_ADDR_W-1:0]   ZERO_REG   = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_use_rs1,
    input  logic                  id_use_rs2,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  id_reg_write,
    input  logic                  id_mem_read,
    input  logic                  flush,
    output logic                  stall,
    output logic                  ex_bubble,
    output logic [1:0]            ForwardA,
    output logic [1:0]            ForwardB
`ifdef HAZ_PERF_CNT_EN
    ,
    output logic [31:0]           stall_cnt,
    output logic [31:0]           fwd_cnt
`endif
);

    import pipe_pkg::*;

    stage_t     r_ex;
    stage_t     r_mem;
    stage_t     r_wb;
    stage_t     w_id_stage;
    logic       w_hit_ex_a;
    logic       w_hit_ex_b;
    logic [1:0] w_next_a;
    logic [1:0] w_next_b;
    logic [1:0] w_load_a;
    logic [1:0] w_load_b;
    logic       w_load_use;
    logic       w_issue;
    logic       w_unused_wb;

    fwd_select #(.ZERO_REG(ZERO_REG)) u_fwd_a (
        .i_src      (id_rs1),
        .i_use      (id_use_rs1),
        .i_ex       (r_ex),
        .i_mem      (r_mem),
        .o_hit_ex   (w_hit_ex_a),
        .o_fwd_next (w_next_a)
    );

    fwd_select #(.ZERO_REG(ZERO_REG)) u_fwd_b (
        .i_src      (id_rs2),
        .i_use      (id_use_rs2),
        .i_ex       (r_ex),
        .i_mem      (r_mem),
        .o_hit_ex   (w_hit_ex_b),
        .o_fwd_next (w_next_b)
    );

    // A load in EX feeding the ID instruction cannot be forwarded in time.
    // A flush discards the consumer, so it overrides the stall.
    assign w_load_use = id_valid & r_ex.mem_read & (w_hit_ex_a | w_hit_ex_b);
    assign stall      = w_load_use & ~flush;
    assign ex_bubble  = stall | flush;
    assign w_issue    = id_valid & ~stall & ~flush;

    assign w_id_stage = '{valid:     1'b1,
                          rd:        id_rd,
                          reg_write: id_reg_write,
                          mem_read:  id_mem_read};

    // The WB shadow is kept for observability only: a consumer in ID whose
    // producer is in WB is served by register-file write-through.
    assign w_unused_wb = ^r_wb;

    // A bubble slot must never carry a forwarding select
    assign w_load_a = ex_bubble ? FWD_RF : w_next_a;
    assign w_load_b = ex_bubble ? FWD_RF : w_next_b;

    // Shadow pipeline advances every edge; ID/EX takes a bubble when the
    // ID instruction is absent, stalled or flushed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ex  <= bubble_stage();
            r_mem <= bubble_stage();
            r_wb  <= bubble_stage();
        end else begin
            r_wb  <= r_mem;
            r_mem <= r_ex;
            r_ex  <= w_issue ? w_id_stage : bubble_stage();
        end
    end

    // Operand selects are computed in ID and registered so they are valid
    // while the same instruction occupies EX.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ForwardA <= FWD_RF;
            ForwardB <= FWD_RF;
        end else begin
            ForwardA <= w_load_a;
            ForwardB <= w_load_b;
        end
    end

`ifdef HAZ_PERF_CNT_EN
    // Event counters wrap naturally at 2^32
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
            fwd_cnt   <= '0;
        end else begin
            if (stall) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
            if ((w_load_a != FWD_RF) || (w_load_b != FWD_RF)) begin
                fwd_cnt <= fwd_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_forwarding_hazard_unit.sv
// Self-checking bench for forwarding_hazard_unit. The reference model keeps
// a short history of what entered EX on each edge (newest first) and derives
// hazards from instruction distance.
module tb_forwarding_hazard_unit;

    logic       clk;
    logic       rst_n;
    logic       id_valid;
    logic [4:0] id_rs1;
    logic [4:0] id_rs2;
    logic       id_use_rs1;
    logic       id_use_rs2;
    logic [4:0] id_rd;
    logic       id_reg_write;
    logic       id_mem_read;
    logic       flush;
    logic       stall;
    logic       ex_bubble;
    logic [1:0] ForwardA;
    logic [1:0] ForwardB;
`ifdef HAZ_PERF_CNT_EN
    logic [31:0] stall_cnt;
    logic [31:0] fwd_cnt;
`endif

    forwarding_hazard_unit dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .id_valid     (id_valid),
        .id_rs1       (id_rs1),
        .id_rs2       (id_rs2),
        .id_use_rs1   (id_use_rs1),
        .id_use_rs2   (id_use_rs2),
        .id_rd        (id_rd),
        .id_reg_write (id_reg_write),
        .id_mem_read  (id_mem_read),
        .flush        (flush),
        .stall        (stall),
        .ex_bubble    (ex_bubble),
        .ForwardA     (ForwardA),
        .ForwardB     (ForwardB)
`ifdef HAZ_PERF_CNT_EN
        ,
        .stall_cnt    (stall_cnt),
        .fwd_cnt      (fwd_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit v;
        int rd;
        bit rw;
        bit mr;
    } slot_t;

    // hist[0] = instruction now in EX, hist[1] = now in MEM, hist[2] = WB
    slot_t hist[$];
    int    expA;
    int    expB;
    int    mStallCnt;
    int    mFwdCnt;
    int    nChecks;
    int    nPass;

    function automatic bit mProduces(int age, int s, bit u);
        slot_t e;
        if (hist.size() <= age) return 1'b0;
        e = hist[age];
        return e.v && e.rw && (e.rd == s) && (s != 0) && u;
    endfunction

    function automatic bit mStall();
        bit lu;
        lu = 1'b0;
        if (id_valid && hist.size() > 0 && hist[0].mr)
            lu = mProduces(0, int'(id_rs1), id_use_rs1) || mProduces(0, int'(id_rs2), id_use_rs2);
        return lu && !flush;
    endfunction

    function automatic int mFwd(int s, bit u);
        if (mStall() || flush) return 0;
        if (mProduces(0, s, u) && !hist[0].mr) return 2;
        if (mProduces(1, s, u)) return 1;
        return 0;
    endfunction

    task automatic drive(input bit v, input int r1, input int r2, input bit u1, input bit u2,
                         input int rd, input bit rw, input bit mr, input bit fl);
        id_valid     = v;
        id_rs1       = 5'(r1);
        id_rs2       = 5'(r2);
        id_use_rs1   = u1;
        id_use_rs2   = u2;
        id_rd        = 5'(rd);
        id_reg_write = rw;
        id_mem_read  = mr;
        flush        = fl;
        #1;
    endtask

    task automatic tick();
        int    nA;
        int    nB;
        bit    ms;
        slot_t e;
        nA = mFwd(int'(id_rs1), id_use_rs1);
        nB = mFwd(int'(id_rs2), id_use_rs2);
        ms = mStall();
        e  = '{v: 1'b0, rd: 0, rw: 1'b0, mr: 1'b0};
        if (id_valid && !ms && !flush)
            e = '{v: 1'b1, rd: int'(id_rd), rw: id_reg_write, mr: id_mem_read};
        @(posedge clk);
        expA = nA;
        expB = nB;
        if (ms) mStallCnt++;
        if (nA != 0 || nB != 0) mFwdCnt++;
        hist.push_front(e);
        if (hist.size() > 3) void'(hist.pop_back());
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(negedge clk);
        hist.delete();
        expA = 0;
        expB = 0;
        mStallCnt = 0;
        mFwdCnt = 0;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        nChecks++; if (stall !== 1'b0) $display("[TB] FAIL reset_stall: got %b expected 0", stall); else nPass++;
        nChecks++; if (ex_bubble !== 1'b0) $display("[TB] FAIL reset_bubble: got %b expected 0", ex_bubble); else nPass++;
        nChecks++; if (ForwardA !== 2'b00) $display("[TB] FAIL reset_fwdA: got %b expected 00", ForwardA); else nPass++;
        nChecks++; if (ForwardB !== 2'b00) $display("[TB] FAIL reset_fwdB: got %b expected 00", ForwardB); else nPass++;
    endtask

    task automatic test_back_to_back();
        do_reset();
        drive(1, 1, 2, 1, 1, 5, 1, 0, 0);
        tick();
        drive(1, 5, 3, 1, 1, 6, 1, 0, 0);
        nChecks++; if (stall !== 1'b0) $display("[TB] FAIL b2b_stall: got %b expected 0", stall); else nPass++;
        tick();
        nChecks++; if (ForwardA !== 2'b10) $display("[TB] FAIL b2b_fwdA: got %b expected 10", ForwardA); else nPass++;
        nChecks++; if (ForwardB !== 2'b00) $display("[TB] FAIL b2b_fwdB: got %b expected 00", ForwardB); else nPass++;
    endtask

    task automatic test_wb_forward();
        do_reset();
        drive(1, 1, 2, 1, 1, 5, 1, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        drive(1, 4, 5, 1, 1, 7, 1, 0, 0);
        tick();
        nChecks++; if (ForwardA !== 2'b00) $display("[TB] FAIL wb_fwdA: got %b expected 00", ForwardA); else nPass++;
        nChecks++; if (ForwardB !== 2'b01) $display("[TB] FAIL wb_fwdB: got %b expected 01", ForwardB); else nPass++;
    endtask

    task automatic test_load_use();
        do_reset();
        drive(1, 2, 0, 1, 0, 8, 1, 1, 0);
        tick();
        drive(1, 8, 8, 1, 1, 9, 1, 0, 0);
        nChecks++; if (stall !== 1'b1) $display("[TB] FAIL lu_stall: got %b expected 1", stall); else nPass++;
        nChecks++; if (ex_bubble !== 1'b1) $display("[TB] FAIL lu_bubble: got %b expected 1", ex_bubble); else nPass++;
        tick();
        nChecks++; if (ForwardA !== 2'b00) $display("[TB] FAIL lu_bubble_fwdA: got %b expected 00", ForwardA); else nPass++;
        nChecks++; if (stall !== 1'b0) $display("[TB] FAIL lu_stall_release: got %b expected 0", stall); else nPass++;
        nChecks++; if (ex_bubble !== 1'b0) $display("[TB] FAIL lu_bubble_release: got %b expected 0", ex_bubble); else nPass++;
        tick();
        nChecks++; if (ForwardA !== 2'b01) $display("[TB] FAIL lu_fwdA: got %b expected 01", ForwardA); else nPass++;
        nChecks++; if (ForwardB !== 2'b01) $display("[TB] FAIL lu_fwdB: got %b expected 01", ForwardB); else nPass++;
    endtask

    task automatic test_zero_reg();
        do_reset();
        drive(1, 1, 2, 1, 1, 0, 1, 1, 0);
        tick();
        drive(1, 0, 0, 1, 1, 4, 1, 0, 0);
        nChecks++; if (stall !== 1'b0) $display("[TB] FAIL x0_stall: got %b expected 0", stall); else nPass++;
        tick();
        nChecks++; if (ForwardA !== 2'b00) $display("[TB] FAIL x0_fwdA: got %b expected 00", ForwardA); else nPass++;
        nChecks++; if (ForwardB !== 2'b00) $display("[TB] FAIL x0_fwdB: got %b expected 00", ForwardB); else nPass++;
    endtask

    task automatic test_flush_load();
        do_reset();
        drive(1, 2, 0, 1, 0, 8, 1, 1, 0);
        tick();
        drive(1, 8, 8, 1, 1, 9, 1, 0, 1);
        nChecks++; if (stall !== 1'b0) $display("[TB] FAIL flush_stall: got %b expected 0", stall); else nPass++;
        nChecks++; if (ex_bubble !== 1'b1) $display("[TB] FAIL flush_bubble: got %b expected 1", ex_bubble); else nPass++;
        tick();
        nChecks++; if (ForwardA !== 2'b00) $display("[TB] FAIL flush_fwdA: got %b expected 00", ForwardA); else nPass++;
        nChecks++; if (ForwardB !== 2'b00) $display("[TB] FAIL flush_fwdB: got %b expected 00", ForwardB); else nPass++;
    endtask

    task automatic test_reset_mid_stall();
        do_reset();
        drive(1, 1, 2, 1, 1, 3, 1, 0, 0);
        tick();
        drive(1, 3, 0, 1, 0, 8, 1, 1, 0);
        tick();
        nChecks++; if (ForwardA !== 2'b10) $display("[TB] FAIL rms_lw_fwdA: got %b expected 10", ForwardA); else nPass++;
        drive(1, 8, 8, 1, 1, 9, 1, 0, 0);
        nChecks++; if (stall !== 1'b1) $display("[TB] FAIL rms_stall_before: got %b expected 1", stall); else nPass++;
        rst_n = 1'b0;
        #1;
        nChecks++; if (stall !== 1'b0) $display("[TB] FAIL rms_stall: got %b expected 0", stall); else nPass++;
        nChecks++; if (ForwardA !== 2'b00) $display("[TB] FAIL rms_fwdA: got %b expected 00", ForwardA); else nPass++;
        nChecks++; if (ForwardB !== 2'b00) $display("[TB] FAIL rms_fwdB: got %b expected 00", ForwardB); else nPass++;
        do_reset();
    endtask

`ifdef HAZ_PERF_CNT_EN
    task automatic test_perf_counters();
        do_reset();
        for (int p = 0; p < 3; p++) begin
            drive(1, 2, 0, 1, 0, 8, 1, 1, 0);
            tick();
            drive(1, 8, 8, 1, 1, 9, 1, 0, 0);
            tick();
            tick();
            drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
            tick();
        end
        nChecks++; if (stall_cnt !== 32'd3) $display("[TB] FAIL perf_stall_cnt: got %0d expected 3", stall_cnt); else nPass++;
        nChecks++; if (fwd_cnt !== 32'(mFwdCnt)) $display("[TB] FAIL perf_fwd_cnt: got %0d expected %0d", fwd_cnt, mFwdCnt); else nPass++;
    endtask
`endif

    task automatic test_random();
        int errs;
        do_reset();
        errs = 0;
        for (int c = 0; c < 300; c++) begin
            drive(($urandom_range(0, 9) < 8), $urandom_range(0, 3), $urandom_range(0, 3),
                  $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 3),
                  $urandom_range(0, 1), $urandom_range(0, 1), ($urandom_range(0, 9) == 0));
            nChecks++;
            if (stall !== mStall()) $display("[TB] FAIL rand_stall c%0d: got %b expected %b", c, stall, mStall());
            else nPass++;
            nChecks++;
            if (ex_bubble !== (mStall() | flush)) $display("[TB] FAIL rand_bubble c%0d: got %b expected %b", c, ex_bubble, mStall() | flush);
            else nPass++;
            tick();
            nChecks++;
            if (ForwardA !== 2'(expA)) $display("[TB] FAIL rand_fwdA c%0d: got %b expected %0d", c, ForwardA, expA);
            else nPass++;
            nChecks++;
            if (ForwardB !== 2'(expB)) $display("[TB] FAIL rand_fwdB c%0d: got %b expected %0d", c, ForwardB, expB);
            else nPass++;
        end
`ifdef HAZ_PERF_CNT_EN
        nChecks++; if (stall_cnt !== 32'(mStallCnt)) $display("[TB] FAIL rand_stall_cnt: got %0d expected %0d", stall_cnt, mStallCnt); else nPass++;
        nChecks++; if (fwd_cnt !== 32'(mFwdCnt)) $display("[TB] FAIL rand_fwd_cnt: got %0d expected %0d", fwd_cnt, mFwdCnt); else nPass++;
`endif
    endtask

    initial begin
        nChecks = 0;
        nPass = 0;
        test_reset();
        test_back_to_back();
        test_wb_forward();
        test_load_use();
        test_zero_reg();
        test_flush_load();
        test_reset_mid_stall();
`ifdef HAZ_PERF_CNT_EN
        test_perf_counters();
`endif
        test_random();
        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule

// File: doc/forwarding_hazard_unit.md
Name: forwarding_hazard_unit

Overview:
- Producer side of the EX-stage operand-select interface in the 5-stage pipeline (IF/ID/EX/MEM/WB).
- Shadows destination-register info for the EX, MEM and WB stages internally.
- Drives registered ForwardA/ForwardB to the EX operand muxes, and a load-use stall/bubble to the front end.
- Sits beside the ID/EX pipeline register; consumes ID-stage decode fields plus the EX branch-flush.

Parameters:
- REG_ADDR_W, 5, register-index width (32 GPRs).
- ZERO_REG, 0, index never forwarded and never causing a stall.

Ports:
- clk  input  1  pipeline clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- id_valid  input  1  ID holds a real instruction
- id_rs1  input  REG_ADDR_W  source 1 index
- id_rs2  input  REG_ADDR_W  source 2 index
- id_use_rs1  input  1  instruction reads rs1
- id_use_rs2  input  1  instruction reads rs2
- id_rd  input  REG_ADDR_W  destination index
- id_reg_write  input  1  instruction writes rd
- id_mem_read  input  1  instruction is a load
- flush  input  1  taken branch/jump resolved in EX; kills ID instruction
- stall  output  1  hold PC and IF/ID register
- ex_bubble  output  1  ID/EX register loads a NOP this edge
- ForwardA  output  2  operand-1 select for instruction in EX
- ForwardB  output  2  operand-2 select for instruction in EX

Behaviour:
- Forward encoding:
  - 2'b00 = register file / immediate path.
  - 2'b01 = WB Write_data.
  - 2'b10 = MEM-stage rd_data (ALU result).
  - 2'b11 is never driven.
- Shadow stages: ex_*, mem_*, wb_*, each holding {valid, rd, reg_write, mem_read}.
- Each rising edge:
  - wb <= mem; mem <= ex.
  - ex <= ID fields if (id_valid & !stall & !flush); otherwise ex <= bubble (valid=0).
- Hazard match, per source s in {rs1, rs2}:
  - hit_X(s) = X.valid & X.reg_write & X.rd == s & s != ZERO_REG & id_use_s.
- Load-use: lu = id_valid & ex.mem_read & (hit_ex(rs1) | hit_ex(rs2)).
- stall = lu & !flush (combinational). ex_bubble = stall | flush.
- Forward regs, computed in ID and registered so they are valid in the same cycle the instruction occupies EX:
  - next = 2'b10 if hit_ex(s) & !ex.mem_read (the producer will be in MEM).
  - else 2'b01 if hit_mem(s) (the producer will be in WB).
  - else 2'b00.
  - MEM priority over WB: the newest producer wins.
- On stall or flush edges, ForwardA/B <= 2'b00, so the bubble carries no forwarding.
- After a load-use stall, the load has moved to MEM. The re-evaluated next value is therefore 2'b01 (load data arrives via WB Write_data). Latency is exactly one stall cycle.
- Producer in WB while consumer is in ID: handled by register-file write-through; the unit gives no forward.
- Simultaneous flush and load-use hazard: flush wins; stall = 0, ex_bubble = 1.
- Reset (async assert, sync-safe deassert):
  - All shadow valid bits = 0.
  - ForwardA = ForwardB = 2'b00.
  - stall = 0, ex_bubble = 0 (both combinational from cleared state).
- Reset mid-stall: stall drops immediately on rst_n low.

Optional Feature:
- Macro HAZ_PERF_CNT_EN.
- Defined:
  - Adds output ports stall_cnt[31:0] and fwd_cnt[31:0], reset to 0.
  - stall_cnt increments on each cycle with stall = 1.
  - fwd_cnt increments on each edge where either registered Forward value loads a non-zero value.
  - Both counters wrap modulo 2^32.
- Undefined: no counter ports or logic; behaviour is otherwise identical.

Decomposition:
- Shared package pipe_pkg:
  - Forward encodings FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10.
  - REG_ADDR_W.
  - Shadow-stage struct typedef.
- Sub-module fwd_select: combinational per-operand priority select (instantiated twice, for rs1 and rs2). Shadow pipeline and stall logic stay in the top module.

Test Plan:
- add x5 <- x1,x2, then sub x6 <- x5,x3 back-to-back -> sub in EX with ForwardA=2'b10, ForwardB=2'b00, stall never asserted.
- add x5 <- x1,x2; nop; or x7 <- x4,x5 -> or in EX with ForwardB=2'b01, ForwardA=2'b00.
- lw x8; then add x9 <- x8,x8 -> stall=1 and ex_bubble=1 for exactly one cycle; then add in EX with ForwardA=ForwardB=2'b01.
- Writes to x0 (rd=0, reg_write=1) followed by a reader of x0 -> Forward=2'b00, no stall.
- lw x8 in EX and dependent instruction in ID with flush=1 the same cycle -> stall=0, ex_bubble=1; the next EX cycle shows Forward=2'b00.
- rst_n low while stall=1 -> stall=0 and Forward=2'b00 immediately. With HAZ_PERF_CNT_EN: 3 load-use pairs give stall_cnt=3.
